// File: rtl/fsm_sdr_param.sv
`timescale 1ns/1ps
// fsm_sdr_param: SDR SDRAM command sequencer.
// Init, refresh, open-page tracking and wrapped bursts.
module fsm_sdr_param #(
  parameter int         ba_size     = 2,
  parameter int         row_size    = 13,
  parameter int         col_size    = 9,
  parameter int         t_rp        = 2,
  parameter int         t_rcd       = 2,
  parameter int         t_rfc       = 7,
  parameter int         close_page  = 0,
  parameter int         init_cycles = 32,
  parameter logic [2:0] init_cl     = 3'b010
) (
  input  logic                                  sdram_clk,
  input  logic                                  sdram_rst_n,
  input  logic [ba_size+row_size+col_size-1:0] adr_i,
  input  logic                                  we_i,
  input  logic [1:0]                            bte_i,
  input  logic                                  req_i,
  output logic                                  ack_o,
  input  logic                                  fifo_empty,
  output logic                                  fifo_rd,
  input  logic                                  refresh_req,
  output logic                                  cmd_aref,
  output logic [ba_size-1:0]                    ba,
  output logic [12:0]                           a,
  output logic [2:0]                            cmd,
  output logic                                  dq_oe,
  output logic                                  cmd_read
);

  localparam int AW = ba_size + row_size + col_size;
  localparam int NB = 1 << ba_size;

  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PCH = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_LMR = 3'b000;

  localparam logic [4:0]  RP_END   = 5'(t_rp - 1);
  localparam logic [4:0]  RP_CNT   = 5'(t_rp);
  localparam logic [4:0]  RCD_END  = 5'(t_rcd - 1);
  localparam logic [4:0]  RFC_LEN  = 5'(t_rfc - 1);
  localparam logic [4:0]  INIT_END = 5'(init_cycles - 1);
  localparam logic        CP       = (close_page != 0);
  localparam logic [12:0] A10      = 13'h0400;
  localparam logic [12:0] LMR_A    =
    {3'b000, 1'b0, 2'b00, init_cl, 1'b0, 3'b001};

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_RFR, S_ADR, S_PCH, S_ACT, S_RW
  } state_t;

  state_t r_state, w_nstate;
  logic [4:0] r_cnt;

  logic [ba_size-1:0]  r_bank;
  logic [row_size-1:0] r_row;
  logic [col_size-1:0] r_col;
  logic                r_we;
  logic [1:0]          r_bte;

  logic [NB-1:0]       r_open;
  logic [row_size-1:0] r_rows [NB];

  logic [2:0]         r_cmd;
  logic [ba_size-1:0] r_ba;
  logic [12:0]        r_a;
  logic r_ack, r_frd, r_aref, r_read, r_dq_oe, r_wr1;

  logic [2:0]          w_cmd;
  logic [ba_size-1:0]  w_ba;
  logic [12:0]         w_a;
  logic w_ack, w_frd, w_aref, w_read;
  logic w_hold, w_cap, w_act, w_clr_all, w_clr_bank;
  logic w_hit, w_last;
  logic [3:0]          w_mask;
  logic [3:0]          w_beat;
  logic [col_size-1:0] w_col;
  logic [11:0]         w_colx;
  logic [12:0]         w_cola;
  logic [4:0]          w_ref_cnt;
  logic [4:0]          w_rfr_end;

  // Burst column generation and bank/row lookup.
  always_comb begin
    w_hit = r_open[r_bank] && (r_rows[r_bank] == r_row);
    unique case (r_bte)
      2'b00:   w_mask = 4'h0;
      2'b01:   w_mask = 4'h3;
      2'b10:   w_mask = 4'h7;
      default: w_mask = 4'hf;
    endcase
    w_beat = r_cnt[4:1];
    w_last = (r_cnt == {w_mask, 1'b1});
    w_col = r_col;
    w_col[3:0] = (r_col[3:0] & ~w_mask)
               | ((r_col[3:0] + w_beat) & w_mask);
    w_colx = 12'(w_col);
    w_cola = {w_colx[11:10], CP, w_colx[9:0]};
    w_ref_cnt = (|r_open) ? RP_CNT : 5'd0;
    w_rfr_end = w_ref_cnt + RFC_LEN;
  end

  // Next state and next command.
  always_comb begin
    w_nstate   = r_state;
    w_cmd      = C_NOP;
    w_ba       = '0;
    w_a        = '0;
    w_ack      = 1'b0;
    w_frd      = 1'b0;
    w_aref     = 1'b0;
    w_read     = 1'b0;
    w_hold     = 1'b0;
    w_cap      = 1'b0;
    w_act      = 1'b0;
    w_clr_all  = 1'b0;
    w_clr_bank = 1'b0;
    unique case (r_state)
      S_INIT: begin
        if (r_cnt == INIT_END) begin
          w_cmd    = C_LMR;
          w_a      = LMR_A;
          w_nstate = S_IDLE;
        end else if (r_cnt == 5'd3) begin
          w_cmd = C_PCH;
          w_a   = A10;
        end else if (r_cnt == 5'd7 || r_cnt == 5'd19) begin
          w_cmd  = C_REF;
          w_aref = 1'b1;
        end
      end
      S_IDLE: begin
        if (refresh_req) begin
          w_nstate = S_RFR;
        end else if (req_i) begin
          w_ack    = 1'b1;
          w_cap    = 1'b1;
          w_nstate = S_ADR;
        end
      end
      S_RFR: begin
        if ((|r_open) && r_cnt == 5'd0) begin
          w_cmd = C_PCH;
          w_a   = A10;
        end else if (r_cnt == w_ref_cnt) begin
          w_cmd  = C_REF;
          w_aref = 1'b1;
        end
        if (r_cnt == w_rfr_end) begin
          w_nstate  = S_IDLE;
          w_clr_all = 1'b1;
        end
      end
      S_ADR: begin
        if (w_hit)
          w_nstate = S_RW;
        else if (!r_open[r_bank])
          w_nstate = S_ACT;
        else
          w_nstate = S_PCH;
      end
      S_PCH: begin
        if (r_cnt == 5'd0) begin
          w_cmd = C_PCH;
          w_ba  = r_bank;
        end
        if (r_cnt == RP_END)
          w_nstate = S_ACT;
      end
      S_ACT: begin
        if (r_cnt == 5'd0) begin
          w_cmd = C_ACT;
          w_ba  = r_bank;
          w_a   = 13'(r_row);
          w_act = 1'b1;
        end
        if (r_cnt == RCD_END)
          w_nstate = S_RW;
      end
      S_RW: begin
        if (!r_cnt[0]) begin
          if (r_we) begin
            if (!fifo_empty) begin
              w_cmd = C_WR;
              w_ba  = r_bank;
              w_a   = w_cola;
              w_frd = 1'b1;
            end else begin
              w_hold = 1'b1;
            end
          end else begin
            w_cmd  = C_RD;
            w_ba   = r_bank;
            w_a    = w_cola;
            w_read = 1'b1;
          end
        end
        if (w_last) begin
          w_nstate   = S_IDLE;
          w_clr_bank = CP;
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  // State register and shared step counter.
  always_ff @(posedge sdram_clk) begin
    if (!sdram_rst_n) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      if (w_nstate != r_state)
        r_cnt <= '0;
      else if (!w_hold)
        r_cnt <= r_cnt + 5'd1;
    end
  end

  // Latch the accepted request.
  always_ff @(posedge sdram_clk) begin
    if (w_cap) begin
      r_bank <= adr_i[AW-1 -: ba_size];
      r_row  <= adr_i[col_size +: row_size];
      r_col  <= adr_i[col_size-1:0];
      r_we   <= we_i;
      r_bte  <= bte_i;
    end
  end

  // Open-bank flags.
  always_ff @(posedge sdram_clk) begin
    if (!sdram_rst_n)
      r_open <= '0;
    else if (w_clr_all)
      r_open <= '0;
    else if (w_act)
      r_open[r_bank] <= 1'b1;
    else if (w_clr_bank)
      r_open[r_bank] <= 1'b0;
  end

  // Row currently open in each bank.
  always_ff @(posedge sdram_clk) begin
    if (w_act)
      r_rows[r_bank] <= r_row;
  end

  // Registered command bus and strobes.
  always_ff @(posedge sdram_clk) begin
    if (!sdram_rst_n) begin
      r_cmd   <= C_NOP;
      r_ba    <= '0;
      r_a     <= '0;
      r_ack   <= 1'b0;
      r_frd   <= 1'b0;
      r_aref  <= 1'b0;
      r_read  <= 1'b0;
      r_dq_oe <= 1'b0;
      r_wr1   <= 1'b0;
    end else begin
      r_cmd   <= w_cmd;
      r_ba    <= w_ba;
      r_a     <= w_a;
      r_ack   <= w_ack;
      r_frd   <= w_frd;
      r_aref  <= w_aref;
      r_read  <= w_read;
      r_wr1   <= (r_cmd == C_WR);
      r_dq_oe <= (r_cmd == C_WR) | r_wr1;
    end
  end

  assign cmd      = r_cmd;
  assign ba       = r_ba;
  assign a        = r_a;
  assign ack_o    = r_ack;
  assign fifo_rd  = r_frd;
  assign cmd_aref = r_aref;
  assign cmd_read = r_read;
  assign dq_oe    = r_dq_oe;

endmodule
